// File: rtl/mem_emu_pkg.sv
// Shared types and helpers for the memory channel emulator.
// Access sizes are in bits; the helpers turn them into byte counts and bit masks.
package mem_emu_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } ch_state_e;

  localparam int ERR_BOTH  = 0;
  localparam int ERR_RANGE = 1;
  localparam int MAX_DW    = 64;

  function automatic logic [31:0] bytes_of(input logic [31:0] size);
    return (size + 32'd7) >> 3;
  endfunction

  function automatic logic [MAX_DW-1:0] size_mask(input logic [31:0] size);
    logic [MAX_DW-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_DW; i++) begin
      if (32'(i) < size) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_emu_channel.sv
// One master channel: window check, latency counter and IDLE/BUSY FSM.
// Exports completion, commit/read strobes, byte enables and the bit mask of the access.
module mem_emu_channel
  import mem_emu_pkg::*;
#(
  parameter int AW        = 14,
  parameter int SW        = 8,
  parameter int DW        = 16,
  parameter int DEPTH     = 64,
  parameter int BASE_ADDR = 0,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1,
  parameter int MW        = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_oe,
  input  logic            i_we,
  input  logic [AW-1:0]   i_addr,
  input  logic [SW-1:0]   i_size,
  output logic            o_rdy,
  output logic            o_rd_en,
  output logic            o_wr_en,
  output logic [DW/8-1:0] o_be,
  output logic [DW-1:0]   o_mask,
  output logic [MW-1:0]   o_offset,
  output logic            o_idle,
  output logic            o_err_both,
  output logic            o_err_range
);

  localparam int MAXL = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CW   = $clog2(MAXL + 1) + 1;

  ch_state_e     r_state, w_state_next;
  logic [CW-1:0] r_count, w_count_next;
  logic [CW-1:0] w_lat;
  logic          w_req, w_in_range, w_rdy;
  logic [32:0]   w_rel;
  logic [31:0]   w_bytes;

  assign w_req   = i_oe ^ i_we;
  assign w_lat   = i_oe ? CW'(READ_LAT) : CW'(WRITE_LAT);
  assign w_bytes = bytes_of(32'(i_size));
  // 33-bit difference: the top bit flags an address below the window
  assign w_rel      = {1'b0, 32'(i_addr)} - {1'b0, 32'(BASE_ADDR)};
  assign w_in_range = !w_rel[32] && ((w_rel[31:0] + w_bytes) <= 32'(DEPTH));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_rdy        = 1'b0;
    o_err_range  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (!w_in_range) begin
            o_err_range = 1'b1;
          end else if (w_lat == CW'(1)) begin
            w_rdy = 1'b1;
          end else begin
            w_state_next = ST_BUSY;
            w_count_next = CW'(2);
          end
        end
      end
      ST_BUSY: begin
        if (r_count == w_lat) begin
          w_rdy        = 1'b1;
          w_state_next = ST_IDLE;
          w_count_next = '0;
        end else begin
          w_count_next = r_count + 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Single-cycle accesses complete combinationally, so hold them off while reset is low
  assign o_rdy       = w_rdy & reset;
  assign o_rd_en     = o_rdy & i_oe;
  assign o_wr_en     = o_rdy & i_we;
  assign o_err_both  = i_oe & i_we;
  assign o_idle      = (r_state == ST_IDLE);
  assign o_offset    = w_rel[MW-1:0];
  assign o_mask      = DW'(size_mask(32'(i_size)));

  genvar gi;
  generate
    for (gi = 0; gi < DW/8; gi++) begin : g_be
      assign o_be[gi] = (32'(gi) < w_bytes);
    end
  endgenerate

endmodule

// File: rtl/mem_channel_emulator.sv
// N-channel external memory emulator over a shared byte array with preload port.
// Same-cycle writes to one byte resolve to the highest channel; reads see pre-edge data.
module mem_channel_emulator
  import mem_emu_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int DW        = 16,
  parameter int AW        = 14,
  parameter int SW        = 8,
  parameter int DEPTH     = 64,
  parameter int BASE_ADDR = 0,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [CHANNELS-1:0]        Mout_oe_ram,
  input  logic [CHANNELS-1:0]        Mout_we_ram,
  input  logic [CHANNELS*AW-1:0]     Mout_addr_ram,
  input  logic [CHANNELS*DW-1:0]     Mout_Wdata_ram,
  input  logic [CHANNELS*SW-1:0]     Mout_data_ram_size,
  output logic [CHANNELS*DW-1:0]     M_Rdata_ram,
  output logic [CHANNELS-1:0]        M_DataRdy,
  input  logic                       load_we,
  input  logic [$clog2(DEPTH)-1:0]   load_addr,
  input  logic [7:0]                 load_data,
  output logic                       load_ready,
  output logic [1:0]                 err_flags
);

  localparam int NB = DW / 8;
  localparam int MW = $clog2(DEPTH);

  logic [7:0]          r_mem [DEPTH];
  logic [1:0]          r_err;
  logic [CHANNELS-1:0] w_rdy, w_rd_en, w_wr_en, w_idle, w_err_both, w_err_range;
  logic [NB-1:0]       w_be     [CHANNELS];
  logic [DW-1:0]       w_mask   [CHANNELS];
  logic [MW-1:0]       w_offset [CHANNELS];
  logic                w_load_ok;

  genvar gi, gj;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [DW-1:0] w_rbytes;

      mem_emu_channel #(
        .AW(AW), .SW(SW), .DW(DW), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR),
        .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT), .MW(MW)
      ) u_ch (
        .clock      (clock),
        .reset      (reset),
        .i_oe       (Mout_oe_ram[gi]),
        .i_we       (Mout_we_ram[gi]),
        .i_addr     (Mout_addr_ram[gi*AW +: AW]),
        .i_size     (Mout_data_ram_size[gi*SW +: SW]),
        .o_rdy      (w_rdy[gi]),
        .o_rd_en    (w_rd_en[gi]),
        .o_wr_en    (w_wr_en[gi]),
        .o_be       (w_be[gi]),
        .o_mask     (w_mask[gi]),
        .o_offset   (w_offset[gi]),
        .o_idle     (w_idle[gi]),
        .o_err_both (w_err_both[gi]),
        .o_err_range(w_err_range[gi])
      );

      for (gj = 0; gj < NB; gj++) begin : g_lane
        logic [MW:0] w_idx;
        assign w_idx = {1'b0, w_offset[gi]} + (MW+1)'(gj);
        assign w_rbytes[gj*8 +: 8] = (w_idx < (MW+1)'(DEPTH)) ? r_mem[w_idx[MW-1:0]] : 8'h00;
      end

      assign M_Rdata_ram[gi*DW +: DW] = w_rd_en[gi] ? (w_rbytes & w_mask[gi]) : '0;
      assign M_DataRdy[gi]            = w_rdy[gi];
    end

    if ((1 << MW) == DEPTH) begin : g_load_pow2
      assign w_load_ok = 1'b1;
    end else begin : g_load_npow2
      assign w_load_ok = (32'(load_addr) < 32'(DEPTH));
    end
  endgenerate

  assign load_ready = ~reset | (&w_idle & ~|(Mout_oe_ram | Mout_we_ram));

  // Ascending channel order makes the last non-blocking write (highest index) win
  always_ff @(posedge clock) begin
    if (load_we && load_ready && w_load_ok) r_mem[load_addr] <= load_data;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_wr_en[c]) begin
        for (int b = 0; b < NB; b++) begin
          if (w_be[c][b]) begin
            r_mem[w_offset[c] + MW'(b)] <=
              (r_mem[w_offset[c] + MW'(b)] & ~w_mask[c][b*8 +: 8]) |
              (Mout_Wdata_ram[c*DW + b*8 +: 8] & w_mask[c][b*8 +: 8]);
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_err <= '0;
    end else begin
      if (|w_err_both)  r_err[ERR_BOTH]  <= 1'b1;
      if (|w_err_range) r_err[ERR_RANGE] <= 1'b1;
    end
  end

  assign err_flags = r_err;

endmodule

// File: tb/tb_mem_channel_emulator.sv
// Scoreboard bench for mem_channel_emulator (default parameters).
// Expected read data comes from a bit-level byte model updated in issue order.
module tb_mem_channel_emulator;

  localparam int CH = 2, DW = 16, AW = 14, SW = 8, DEPTH = 64;
  localparam int RLAT = 2, WLAT = 1;

  logic                 clock, reset;
  logic [CH-1:0]        Mout_oe_ram, Mout_we_ram;
  logic [CH*AW-1:0]     Mout_addr_ram;
  logic [CH*DW-1:0]     Mout_Wdata_ram;
  logic [CH*SW-1:0]     Mout_data_ram_size;
  logic [CH*DW-1:0]     M_Rdata_ram;
  logic [CH-1:0]        M_DataRdy;
  logic                 load_we;
  logic [5:0]           load_addr;
  logic [7:0]           load_data;
  logic                 load_ready;
  logic [1:0]           err_flags;

  mem_channel_emulator dut (
    .clock             (clock),
    .reset             (reset),
    .Mout_oe_ram       (Mout_oe_ram),
    .Mout_we_ram       (Mout_we_ram),
    .Mout_addr_ram     (Mout_addr_ram),
    .Mout_Wdata_ram    (Mout_Wdata_ram),
    .Mout_data_ram_size(Mout_data_ram_size),
    .M_Rdata_ram       (M_Rdata_ram),
    .M_DataRdy         (M_DataRdy),
    .load_we           (load_we),
    .load_addr         (load_addr),
    .load_data         (load_data),
    .load_ready        (load_ready),
    .err_flags         (err_flags)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  mdl [DEPTH];
  logic [15:0] exp_q [CH][$];
  logic [15:0] mon_rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_read(input int addr, input int size);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < size; i++) v[i] = mdl[addr + i/8][i%8];
    return v;
  endfunction

  task automatic model_write(input int addr, input logic [15:0] data, input int size);
    for (int i = 0; i < size; i++) mdl[addr + i/8][i%8] = data[i];
  endtask

  task automatic set_req(input int c, input bit oe, input bit we, input int addr,
                         input int data, input int size);
    Mout_oe_ram[c]                    = oe;
    Mout_we_ram[c]                    = we;
    Mout_addr_ram[c*AW +: AW]         = AW'(addr);
    Mout_Wdata_ram[c*DW +: DW]        = DW'(data);
    Mout_data_ram_size[c*SW +: SW]    = SW'(size);
  endtask

  task automatic clr_req(input int c);
    set_req(c, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic wait_rdy(input int c, input int budget, output int lat);
    lat = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clock);
      if (M_DataRdy[c]) begin
        lat = i;
        return;
      end
    end
    check_eq($sformatf("timeout_ch%0d", c), 32'(M_DataRdy[c]), 32'd1);
  endtask

  task automatic access(input int c, input bit wr, input int addr, input int data, input int size);
    int lat;
    exp_q[c].push_back(wr ? 16'h0000 : model_read(addr, size));
    if (wr) model_write(addr, 16'(data), size);
    @(posedge clock); #1;
    set_req(c, !wr, wr, addr, data, size);
    wait_rdy(c, 8, lat);
    check_eq($sformatf("lat_ch%0d_%s_a%0d", c, wr ? "wr" : "rd", addr), lat, wr ? WLAT : RLAT);
    @(posedge clock); #1;
    clr_req(c);
  endtask

  // Scoreboard: pop one expectation per completion; idle channels must return 0
  always @(negedge clock) begin
    for (int c = 0; c < CH; c++) begin
      mon_rd = M_Rdata_ram[c*DW +: DW];
      if (M_DataRdy[c]) begin
        if (exp_q[c].size() == 0) begin
          check_eq($sformatf("unexpected_rdy_ch%0d", c), 32'(M_DataRdy[c]), 32'd0);
        end else begin
          check_eq($sformatf("rdata_ch%0d", c), 32'(mon_rd), 32'(exp_q[c].pop_front()));
          $display("ch%0d done rdata=0x%04h", c, mon_rd);
        end
      end else begin
        check_eq($sformatf("rdata_idle_ch%0d", c), 32'(mon_rd), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cnt, sz, bytes, c, addr;
    int sizes [5] = '{0, 4, 8, 12, 16};

    reset = 1'b0;
    Mout_oe_ram = '0; Mout_we_ram = '0; Mout_addr_ram = '0;
    Mout_Wdata_ram = '0; Mout_data_ram_size = '0;
    load_we = 1'b0; load_addr = '0; load_data = '0;

    repeat (2) @(negedge clock);
    check_eq("rst_rdy", 32'(M_DataRdy), 32'd0);
    check_eq("rst_rdata", 32'(M_Rdata_ram), 32'd0);
    check_eq("rst_err", 32'(err_flags), 32'd0);
    check_eq("rst_load_ready", 32'(load_ready), 32'd1);
    @(posedge clock); #1;
    reset = 1'b1;

    // Preload the whole array
    for (int i = 0; i < DEPTH; i++) begin
      mdl[i] = 8'((i * 37 + 5) & 8'hFF);
      if (i == 0) mdl[i] = 8'h11;
      if (i == 1) mdl[i] = 8'h22;
      if (i == 3 || i == 4) mdl[i] = 8'hFF;
      @(posedge clock); #1;
      load_we = 1'b1; load_addr = 6'(i); load_data = mdl[i];
      @(negedge clock);
      check_eq($sformatf("load_ready_%0d", i), 32'(load_ready), 32'd1);
    end
    @(posedge clock); #1;
    load_we = 1'b0;

    access(0, 1'b0, 0, 0, 16);            // 0x2211
    access(1, 1'b1, 3, 16'hABCD, 12);     // bytes 3,4 -> 0xCD,0xFB
    access(0, 1'b0, 3, 0, 16);
    access(1, 1'b0, 4, 0, 8);

    // Both channels write byte 5 in the same cycle: ch1 wins
    model_write(5, 16'h0001, 8);
    model_write(5, 16'h0002, 8);
    exp_q[0].push_back(16'h0000);
    exp_q[1].push_back(16'h0000);
    @(posedge clock); #1;
    set_req(0, 1'b0, 1'b1, 5, 16'h0001, 8);
    set_req(1, 1'b0, 1'b1, 5, 16'h0002, 8);
    @(negedge clock);
    check_eq("dual_write_rdy", 32'(M_DataRdy), 32'd3);
    @(posedge clock); #1;
    clr_req(0); clr_req(1);
    access(0, 1'b0, 5, 0, 8);

    // Read completes in the cycle the other channel's write commits
    exp_q[0].push_back(model_read(5, 8));
    @(posedge clock); #1;
    set_req(0, 1'b1, 1'b0, 5, 0, 8);
    @(posedge clock); #1;
    model_write(5, 16'h0007, 8);
    exp_q[1].push_back(16'h0000);
    set_req(1, 1'b0, 1'b1, 5, 16'h0007, 8);
    @(negedge clock);
    check_eq("rbw_rdy", 32'(M_DataRdy), 32'd3);
    @(posedge clock); #1;
    clr_req(0); clr_req(1);
    access(0, 1'b0, 5, 0, 8);

    // Back-to-back reads on a held request
    exp_q[0].push_back(model_read(10, 16));
    exp_q[0].push_back(model_read(10, 16));
    @(posedge clock); #1;
    set_req(0, 1'b1, 1'b0, 10, 0, 16);
    wait_rdy(0, 8, lat);
    check_eq("b2b_lat0", lat, RLAT);
    wait_rdy(0, 8, lat);
    check_eq("b2b_lat1", lat, RLAT);
    @(posedge clock); #1;
    clr_req(0);

    // Preload is dropped while a channel is busy
    exp_q[0].push_back(model_read(0, 8));
    @(posedge clock); #1;
    set_req(0, 1'b1, 1'b0, 0, 0, 8);
    load_we = 1'b1; load_addr = 6'd20; load_data = 8'h5A;
    @(negedge clock);
    check_eq("load_ready_pending", 32'(load_ready), 32'd0);
    @(negedge clock);
    check_eq("load_ready_busy", 32'(load_ready), 32'd0);
    check_eq("load_gate_rdy", 32'(M_DataRdy), 32'd1);
    @(posedge clock); #1;
    load_we = 1'b0;
    clr_req(0);
    access(1, 1'b0, 20, 0, 8);

    // Random single accesses, odd sizes included
    for (int n = 0; n < 24; n++) begin
      c     = int'($urandom_range(0, 1));
      sz    = sizes[$urandom_range(0, 4)];
      bytes = (sz + 7) / 8;
      addr  = int'($urandom_range(0, DEPTH - bytes));
      access(c, 1'($urandom_range(0, 1)), addr, int'($urandom), sz);
    end
    for (int a = 0; a < 8; a++) access(a % 2, 1'b0, a * 8, 0, 16);

    // Errors: out-of-window read, then oe&we
    check_eq("err_before", 32'(err_flags), 32'd0);
    @(posedge clock); #1;
    set_req(0, 1'b1, 1'b0, DEPTH - 1, 0, 16);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (M_DataRdy[0]) cnt++;
    end
    check_eq("oor_rdy_count", cnt, 0);
    check_eq("err_range", 32'(err_flags), 32'd2);
    @(posedge clock); #1;
    clr_req(0);
    set_req(1, 1'b1, 1'b1, 0, 0, 8);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (M_DataRdy[1]) cnt++;
    end
    check_eq("both_rdy_count", cnt, 0);
    @(posedge clock); #1;
    clr_req(1);
    @(negedge clock);
    check_eq("err_sticky", 32'(err_flags), 32'd3);

    // Reset in the DataRdy cycle of a read; a write held during reset must not commit
    @(posedge clock); #1;
    set_req(0, 1'b1, 1'b0, 8, 0, 16);
    @(posedge clock); #1;
    reset = 1'b0;
    set_req(1, 1'b0, 1'b1, 7, 16'h0099, 8);
    @(negedge clock);
    check_eq("abort_rdy", 32'(M_DataRdy), 32'd0);
    check_eq("abort_rdata", 32'(M_Rdata_ram), 32'd0);
    check_eq("abort_err", 32'(err_flags), 32'd0);
    check_eq("abort_load_ready", 32'(load_ready), 32'd1);
    repeat (3) @(posedge clock);
    #1;
    clr_req(0); clr_req(1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check_eq("post_rst_load_ready", 32'(load_ready), 32'd1);
    check_eq("post_rst_rdy", 32'(M_DataRdy), 32'd0);
    access(0, 1'b0, 7, 0, 16);
    access(1, 1'b0, 0, 0, 16);

    repeat (2) @(negedge clock);
    for (int c2 = 0; c2 < CH; c2++)
      check_eq($sformatf("queue_drained_ch%0d", c2), exp_q[c2].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
